// File: rtl/console_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : console_tx_port
// Description : Memory-mapped console transmitter on the MIPS_CPU data bus.
//               Stores to the data register (BASE_ADDR) queue data_bus[15:8]
//               into a FIFO. The FIFO drains onto an 8N1 UART line. A stored
//               NUL byte sets the sticky halt flag instead of being queued.
//               BASE_ADDR+1 is the status (read) / control (write) register.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               data_bus        - bidirectional CPU bus, driven on status reads
//               data_address    - word address
//               data_cs/data_rw - bus cycle valid / 1=write 0=read
//               uart_tx         - serial output, idles high
//               halt            - sticky end-of-output marker
// Revision    : 1.0 - initial release
// ============================================================================
module console_tx_port #(
    parameter logic [29:0] BASE_ADDR    = 30'h0,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] data_bus,
    input  logic [29:0] data_address,
    input  logic        data_cs,
    input  logic        data_rw,
    output logic        uart_tx,
    output logic        halt
);

    localparam int          c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int          c_cnt_w     = c_ptr_w + 1;
    localparam int          c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [29:0] c_ctrl_addr = BASE_ADDR + 30'd1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    // Flags
    logic                r_overflow;
    logic                r_halt;

    // Transmitter
    logic [1:0]          r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    // Bus decode and datapath
    logic                w_wr_data;
    logic                w_wr_ctrl;
    logic                w_rd;
    logic [7:0]          w_char;
    logic                w_char_nul;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_baud_done;
    logic [2:0]          w_next_idx;
    logic [7:0]          w_count8;
    logic [31:0]         w_status;
    logic                w_unused_bus;

    assign w_wr_data  = data_cs && data_rw && (data_address == BASE_ADDR);
    assign w_wr_ctrl  = data_cs && data_rw && (data_address == c_ctrl_addr);
    assign w_rd       = data_cs && !data_rw &&
                        ((data_address == BASE_ADDR) || (data_address == c_ctrl_addr));
    assign w_char     = data_bus[15:8];
    assign w_char_nul = (w_char == 8'h00);

    // Full/empty come from the pre-edge count, so a push while full is dropped
    // even when the transmitter pops on the same edge.
    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_push     = w_wr_data && !w_char_nul && !w_full;

    assign w_baud_done = (r_baud == c_baud_last);
    assign w_next_idx  = r_bit_idx + 3'd1;

    // Pop in IDLE as soon as data is present, or at the end of a stop bit so
    // that consecutive frames abut with no idle gap.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            c_st_idle: w_pop = !w_empty;
            c_st_stop: w_pop = w_baud_done && !w_empty;
            default:   w_pop = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_data && w_char_nul) begin
                r_halt <= 1'b1;
            end
            if (w_wr_data && !w_char_nul && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_ctrl && data_bus[0]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM: every state lasts CLKS_PER_BIT cycles; the baud counter
    // restarts at each state or bit change. uart_tx is registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= c_st_start;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= c_st_data;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                c_st_data: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_st_stop;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                default: begin // c_st_stop
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= c_st_start;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_st_idle;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status read-back, driven combinationally during a matching read
    // ------------------------------------------------------------------------
    assign w_count8 = 8'(r_count);
    assign w_status = {(r_state != c_st_idle), w_full, w_empty, r_overflow, r_halt,
                       19'd0, w_count8};

    assign data_bus = w_rd ? w_status : 32'hzzzz_zzzz;

    // Bus bits that carry no meaning for this port on writes.
    assign w_unused_bus = ^{data_bus[31:16], data_bus[7:1]};

    assign uart_tx = r_tx;
    assign halt    = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_console_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_tx_port
// Description : Self-checking bench for console_tx_port. A timeline model
//               (character queue plus frame start time) predicts the serial
//               line, halt and the status word every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_tx_port;

    localparam logic [29:0] c_base  = 30'h100;
    localparam int          c_cpb   = 4;
    localparam int          c_depth = 4;
    localparam int          c_frame = 10 * c_cpb;

    logic        clk;
    logic        rst;
    logic        data_cs;
    logic        data_rw;
    logic [29:0] data_address;
    logic [31:0] drv_val;
    logic        drv_en;
    wire  [31:0] data_bus;
    wire         uart_tx;
    wire         halt;

    assign data_bus = drv_en ? drv_val : 32'hzzzz_zzzz;

    console_tx_port #(
        .BASE_ADDR    (c_base),
        .CLKS_PER_BIT (c_cpb),
        .FIFO_DEPTH   (c_depth)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_bus     (data_bus),
        .data_address (data_address),
        .data_cs      (data_cs),
        .data_rw      (data_rw),
        .uart_tx      (uart_tx),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    int         m_cyc   = 0;
    int         m_start = -1;   // edge at which the current frame began, -1 = line idle
    logic [7:0] m_cur   = 8'h00;
    logic       m_halt  = 1'b0;
    logic       m_ovf   = 1'b0;

    function automatic logic m_tx();
        int o;
        int b;
        if (m_start < 0) return 1'b1;
        o = m_cyc - m_start;
        b = o / c_cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s     = 32'h0;
        s[31] = (m_start >= 0);
        s[30] = (m_q.size() == c_depth);
        s[29] = (m_q.size() == 0);
        s[28] = m_ovf;
        s[27] = m_halt;
        s[7:0] = 8'(m_q.size());
        return s;
    endfunction

    task automatic model_edge(input logic r, input logic cs, input logic rw,
                              input logic [29:0] a, input logic [31:0] d);
        int         pre;
        logic       pop;
        logic [7:0] c;
        m_cyc++;
        if (r) begin
            m_q.delete();
            m_start = -1;
            m_halt  = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        pre = m_q.size();
        pop = 1'b0;
        if (m_start < 0) begin
            pop = (pre > 0);
        end else if (m_cyc - m_start == c_frame) begin
            pop = (pre > 0);
            if (!pop) m_start = -1;
        end
        if (pop) begin
            m_cur   = m_q.pop_front();
            m_start = m_cyc;
        end
        if (cs && rw && a == c_base) begin
            c = d[15:8];
            if (c == 8'h00)          m_halt = 1'b1;
            else if (pre == c_depth) m_ovf  = 1'b1;
            else                     m_q.push_back(c);
        end else if (cs && rw && a == c_base + 30'd1 && d[0]) begin
            m_ovf = 1'b0;
        end
    endtask

    // One bus cycle: apply inputs, check read data mid-cycle, advance the
    // model on the edge and check the line and halt just after it.
    task automatic step(input logic r, input logic cs, input logic rw,
                        input logic [29:0] a, input logic [31:0] d,
                        output logic [31:0] bus_seen);
        logic [31:0] exp_s;
        logic        exp_tx;
        rst          = r;
        data_cs      = cs;
        data_rw      = rw;
        data_address = a;
        drv_val      = d;
        drv_en       = cs && rw;
        @(negedge clk);
        bus_seen = data_bus;
        if (cs && !rw && (a == c_base || a == c_base + 30'd1)) begin
            exp_s = m_status();
            n_vec++;
            if (data_bus !== exp_s) begin
                n_err++;
                $display("FAIL status_read cyc %0d addr %h: got %h, want %h", m_cyc, a, data_bus, exp_s);
            end
        end else if (!(cs && rw)) begin
            // An undriven net reads as Z, or as 0 in a two-state simulator;
            // a driven status word is never 0 (empty or a nonzero count).
            n_vec++;
            if (!(data_bus === 32'hzzzz_zzzz || data_bus === 32'h0)) begin
                n_err++;
                $display("FAIL bus_float cyc %0d addr %h: got %h, want z", m_cyc, a, data_bus);
            end
        end
        @(posedge clk);
        model_edge(r, cs, rw, a, d);
        #1;
        exp_tx = m_tx();
        n_vec++;
        if (uart_tx !== exp_tx) begin
            n_err++;
            $display("FAIL uart_tx cyc %0d: got %b, want %b", m_cyc, uart_tx, exp_tx);
        end
        n_vec++;
        if (halt !== m_halt) begin
            n_err++;
            $display("FAIL halt cyc %0d: got %b, want %b", m_cyc, halt, m_halt);
        end
    endtask

    task automatic idle(input int n);
        logic [31:0] s;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, c_base, 32'h0, s);
    endtask

    task automatic rd_status(input logic [29:0] a, output logic [31:0] s);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, s);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        logic [31:0] s;
        step(1'b0, 1'b1, 1'b1, a, d, s);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] s;
        step(1'b1, 1'b0, 1'b0, c_base, 32'h0, s);
        step(1'b1, 1'b0, 1'b0, c_base, 32'h0, s);
        rd_status(c_base, s);
        n_vec++;
        if (s !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL reset_status: got %h, want 20000000", s);
        end
    endtask

    task automatic test_single_char();
        logic [31:0] s;
        wr(c_base, 32'hABCD_41EF);
        // Poll status every cycle of the frame and one beyond.
        for (int i = 0; i < c_frame + 2; i++) rd_status(c_base, s);
        n_vec++;
        if (s !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL single_after: got %h, want 20000000", s);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        for (int i = 0; i < 6; i++) wr(c_base, {16'h0, 8'(8'h31 + i), 8'h00});
        rd_status(c_base + 30'd1, s);
        n_vec++;
        if (s !== 32'hD000_0004) begin
            n_err++;
            $display("FAIL overflow_status: got %h, want d0000004", s);
        end
        idle(5 * c_frame + 4);
        wr(c_base + 30'd1, 32'h0000_0001);
        rd_status(c_base, s);
        n_vec++;
        if (s !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL overflow_clear: got %h, want 20000000", s);
        end
    endtask

    task automatic test_nul();
        logic [31:0] s;
        wr(c_base, 32'h1234_00FF);
        rd_status(c_base, s);
        n_vec++;
        if (s !== 32'h2800_0000) begin
            n_err++;
            $display("FAIL nul_status: got %h, want 28000000", s);
        end
        idle(c_frame);
    endtask

    task automatic test_decode();
        logic [31:0] s;
        wr(c_base + 30'd2, 32'h0000_4100);
        wr(c_base - 30'd1, 32'h0000_4101);
        idle(c_frame);
        rd_status(c_base + 30'd2, s);
        rd_status(c_base + 30'd1, s);
        rd_status(c_base, s);
    endtask

    task automatic test_random();
        logic [31:0] s;
        int          r;
        logic [7:0]  c;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                for (int k = 0; k < 6; k++) wr(c_base, {$urandom_range(0, 65535), 8'($urandom_range(1, 255)), 8'($urandom)});
            end else if (r < 5) begin
                c = ($urandom_range(0, 49) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                wr(c_base, {16'($urandom), c, 8'($urandom)});
            end else if (r < 7) begin
                wr(c_base + 30'd1, $urandom);
            end else if (r < 13) begin
                rd_status(c_base + 30'($urandom_range(0, 2)), s);
            end else if (r < 14) begin
                wr(c_base + 30'd2 + 30'($urandom_range(0, 1000)), $urandom);
            end else begin
                idle(1);
            end
        end
        idle(6 * c_frame);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] s;
        wr(c_base, 32'h0000_5500);
        wr(c_base, 32'h0000_AA00);
        wr(c_base, 32'h0000_0F00);
        idle(15);   // next edge falls inside data bit 3 of the first frame
        step(1'b1, 1'b0, 1'b0, c_base, 32'h0, s);
        n_vec++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_tx: got %b, want 1", uart_tx);
        end
        rd_status(c_base, s);
        n_vec++;
        if (s !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL midframe_status: got %h, want 20000000", s);
        end
        idle(3 * c_frame);
    endtask

    initial begin
        rst          = 1'b1;
        data_cs      = 1'b0;
        data_rw      = 1'b0;
        data_address = 30'h0;
        drv_val      = 32'h0;
        drv_en       = 1'b0;
        test_reset();
        test_single_char();
        test_overflow();
        test_decode();
        test_nul();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
